// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : MIPS instruction fetch, PC register and IF/ID pipeline latch
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Stall,
    input  logic [1:0]             PCSrc,
    input  logic                   Flush,
    input  logic [31:0]            InstData,
    output logic [31:0]            InstAddr,
    output logic [31:0]            PC,
    output logic [31:0]            IFID_Instruction,
    output logic [31:0]            IFID_PCPlus4,
    output logic                   IFID_Valid,
    output logic [FLUSH_CNT_W-1:0] FlushCount
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign pc_plus4      = PC + 32'd4;
    assign branch_offset = {{14{IFID_Instruction[15]}}, IFID_Instruction[15:0], 2'b00};
    assign branch_target = IFID_PCPlus4 + branch_offset;
    assign jump_target   = {IFID_PCPlus4[31:28], IFID_Instruction[25:0], 2'b00};
    assign InstAddr      = PC;

    // Reserved PCSrc encoding falls through to sequential fetch.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01:   next_pc = jump_target;
            2'b10:   next_pc = branch_target;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC               <= RESET_PC;
            IFID_Instruction <= 32'h0000_0000;
            IFID_PCPlus4     <= 32'h0000_0000;
            IFID_Valid       <= 1'b0;
            FlushCount       <= '0;
        end else if (!Stall) begin
            PC <= next_pc;
            if (Flush) begin
                IFID_Instruction <= 32'h0000_0000;
                IFID_PCPlus4     <= 32'h0000_0000;
                IFID_Valid       <= 1'b0;
                if (FlushCount != {FLUSH_CNT_W{1'b1}})
                    FlushCount <= FlushCount + 1'b1;
            end else begin
                IFID_Instruction <= InstData;
                IFID_PCPlus4     <= pc_plus4;
                IFID_Valid       <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : directed scoreboard bench for fetch_stage (4-bit flush counter)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam int FCW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           Stall = 1'b0;
    logic [1:0]     PCSrc = 2'b00;
    logic           Flush = 1'b0;
    logic [31:0]    InstData = 32'h0;
    logic [31:0]    InstAddr;
    logic [31:0]    PC;
    logic [31:0]    IFID_Instruction;
    logic [31:0]    IFID_PCPlus4;
    logic           IFID_Valid;
    logic [FCW-1:0] FlushCount;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CNT_W (FCW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Stall            (Stall),
        .PCSrc            (PCSrc),
        .Flush            (Flush),
        .InstData         (InstData),
        .InstAddr         (InstAddr),
        .PC               (PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FlushCount       (FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]    pc;
        logic [31:0]    ins;
        logic [31:0]    p4;
        logic           v;
        logic [FCW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    logic [31:0]    m_pc, m_ins, m_p4;
    logic           m_v;
    logic [FCW-1:0] m_fc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string pfx, input exp_t e);
        check({pfx, " pc"},    PC,               e.pc);
        check({pfx, " addr"},  InstAddr,         e.pc);
        check({pfx, " ins"},   IFID_Instruction, e.ins);
        check({pfx, " p4"},    IFID_PCPlus4,     e.p4);
        check({pfx, " valid"}, {31'b0, IFID_Valid}, {31'b0, e.v});
        check({pfx, " fcnt"},  {28'b0, FlushCount}, {28'b0, e.fc});
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.fc = m_fc;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0; m_fc = '0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare.
    task automatic cycle(input logic st, input logic [1:0] src, input logic fl,
                         input logic [31:0] d, input string tag);
        exp_t e;
        logic [31:0] nxt;
        Stall = st; PCSrc = src; Flush = fl; InstData = d;
        if (!st) begin
            case (src)
                2'b01:   nxt = {m_p4[31:28], m_ins[25:0], 2'b00};
                2'b10:   nxt = m_p4 + {{14{m_ins[15]}}, m_ins[15:0], 2'b00};
                default: nxt = m_pc + 32'd4;
            endcase
            if (fl) begin
                m_ins = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
                if (m_fc != {FCW{1'b1}}) m_fc = m_fc + 1'b1;
            end else begin
                m_ins = d; m_p4 = m_pc + 32'd4; m_v = 1'b1;
            end
            m_pc = nxt;
        end
        sb.push_back(model_snapshot());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            check_state(tag, e);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic rst_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state(tag, model_snapshot());
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", model_snapshot());
        rst = 1'b0;

        cycle(0, 2'b00, 0, 32'h8C01_0004, "run0");
        cycle(0, 2'b00, 0, 32'h0022_1820, "run1");
        cycle(0, 2'b00, 0, 32'hAC03_0008, "run2");
        check("run2 pc const", PC, 32'h0000_000C);
        check("run2 p4 const", IFID_PCPlus4, 32'h0000_000C);

        cycle(0, 2'b00, 0, 32'h1000_0003, "br_fetch");
        cycle(0, 2'b10, 1, 32'h0000_0000, "branch");
        check("branch pc const", PC, 32'h0000_001C);
        check("branch fc const", {28'b0, FlushCount}, 32'd1);

        cycle(0, 2'b00, 0, 32'h0800_0040, "j_fetch");
        cycle(0, 2'b01, 1, 32'h0000_0000, "jump");
        check("jump pc const", PC, 32'h0000_0100);

        cycle(0, 2'b00, 0, 32'h1000_0002, "st_fetch");
        cycle(1, 2'b10, 1, 32'h1111_1111, "stall0");
        cycle(1, 2'b10, 1, 32'h2222_2222, "stall1");
        check("stall pc const", PC, 32'h0000_0104);
        cycle(0, 2'b10, 1, 32'h0000_0000, "st_rel");
        check("st_rel pc const", PC, 32'h0000_010C);
        cycle(0, 2'b00, 0, 32'h1000_FFBB, "neg_fetch");
        cycle(0, 2'b10, 1, 32'h0000_0000, "neg_br");
        check("neg_br pc const", PC, 32'hFFFF_FFFC);
        cycle(0, 2'b00, 0, 32'h1000_FFFF, "wrap");
        check("wrap pc const", PC, 32'h0000_0000);
        check("wrap p4 const", IFID_PCPlus4, 32'h0000_0000);
        cycle(0, 2'b00, 0, 32'h1000_FFFF, "m1_fetch");
        cycle(0, 2'b10, 1, 32'h0000_0000, "m1_br");
        check("m1_br pc const", PC, 32'h0000_0000);

        cycle(0, 2'b00, 0, 32'h1000_FFFD, "hi_fetch");
        cycle(0, 2'b10, 1, 32'h0000_0000, "hi_br");
        cycle(0, 2'b00, 0, 32'h0800_0040, "hij_fetch");
        cycle(0, 2'b01, 1, 32'h0000_0000, "hi_jump");
        check("hi_jump pc const", PC, 32'hF000_0100);

        cycle(0, 2'b00, 0, 32'h0000_0000, "free");
        cycle(0, 2'b01, 0, 32'h0123_4567, "jmp_noflush");
        for (int i = 0; i < 10; i++)
            cycle(0, (i % 2) ? 2'b11 : 2'b00, 1, 32'hDEAD_0000 | i, "sat");
        check("sat fc const", {28'b0, FlushCount}, 32'h0000_000F);
        cycle(1, 2'b10, 1, 32'h0, "sat_stall");

        rst_pulse("rst1");
        for (int i = 0; i < 16; i++)
            cycle(0, 2'b00, 0, 32'h2000_0000 + i, "cnt");
        check("cnt pc const", PC, 32'h0000_0040);
        rst_pulse("rst2");
        check("rst2 valid const", {31'b0, IFID_Valid}, 32'd0);
        cycle(0, 2'b00, 0, 32'h8C01_0004, "post_rst");
        check("post_rst pc const", PC, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
